alu_arbiter: RTL and testbench

//   Shares one 32-bit ALU between two requesters (e.g. execute stage and address/branch unit).

---
 rtl/alu_arbiter.sv | 127 ++++++++++++
 tb/tb_alu_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// One operation in flight; result returned on an ID-tagged response channel.
module alu_arbiter #(
   parameter int WIDTH = 32,
   parameter int OPW   = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [OPW-1:0]   req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [OPW-1:0]   req1_op,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             rsp_err,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [OPW-1:0]   alu_control,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             prio;
   logic             grant0;
   logic             grant1;
   logic             accept;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [OPW-1:0]   op_c;
   logic             op_id;
   logic             op_legal;

   // Grant selection (IDLE only) and next-state logic.
   always_comb begin
      grant0     = 1'b0;
      grant1     = 1'b0;
      state_next = state;
      case (state)
         IDLE: begin
            if (req0_valid && req1_valid) begin
               grant0 = ~prio;
               grant1 = prio;
            end else begin
               grant0 = req0_valid;
               grant1 = req1_valid;
            end
            if (req0_valid || req1_valid) state_next = EXEC;
         end
         EXEC:    state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Only the op codes the ALU implements are passed through; others flag an error.
   always_comb begin
      op_legal = (op_c == OPW'(0)) || (op_c == OPW'(1)) || (op_c == OPW'(2)) ||
                 (op_c == OPW'(6)) || (op_c == OPW'(7));
   end

   assign accept      = grant0 | grant1;
   assign req0_ready  = grant0 & ~reset;
   assign req1_ready  = grant1 & ~reset;
   assign rsp_valid   = (state == RESP);
   assign alu_a       = op_a;
   assign alu_b       = op_b;
   assign alu_control = op_c;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Operand latch on accept, priority update, and response capture in EXEC.
   always_ff @(posedge clk) begin
      if (reset) begin
         prio       <= 1'b0;
         op_a       <= '0;
         op_b       <= '0;
         op_c       <= '0;
         op_id      <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
         rsp_err    <= 1'b0;
      end else begin
         if (accept) begin
            op_a  <= grant1 ? req1_a  : req0_a;
            op_b  <= grant1 ? req1_b  : req0_b;
            op_c  <= grant1 ? req1_op : req0_op;
            op_id <= grant1;
            prio  <= ~grant1;
         end
         if (state == EXEC) begin
            rsp_id <= op_id;
            if (op_legal) begin
               rsp_result <= alu_result;
               rsp_zero   <= alu_zero;
               rsp_err    <= 1'b0;
            end else begin
               rsp_result <= '0;
               rsp_zero   <= 1'b1;
               rsp_err    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level reference model.
module tb_alu_arbiter;

   logic        clk;
   logic        reset;
   logic        req0_valid, req0_ready;
   logic [31:0] req0_a, req0_b;
   logic [2:0]  req0_op;
   logic        req1_valid, req1_ready;
   logic [31:0] req1_a, req1_b;
   logic [2:0]  req1_op;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
   logic [31:0] rsp_result;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [2:0]  alu_control;
   logic        alu_zero;

   int   checks   = 0;
   int   failures = 0;
   logic tie_pick = 1'b0;  // requester a tie goes to: the one that did not win last

   alu_arbiter #(.WIDTH(32), .OPW(3)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_zero(rsp_zero), .rsp_err(rsp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
      .alu_result(alu_result), .alu_zero(alu_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in ALU; unsupported codes give garbage that must never reach rsp_result.
   always_comb begin
      alu_result = 32'hDEADBEEF;
      case (alu_control)
         3'd0: alu_result = alu_a & alu_b;
         3'd1: alu_result = alu_a | alu_b;
         3'd2: alu_result = alu_a + alu_b;
         3'd6: alu_result = alu_a - alu_b;
         3'd7: alu_result = (alu_a < alu_b) ? 32'd1 : 32'd0;
         default: alu_result = 32'hDEADBEEF;
      endcase
      alu_zero = (alu_result == 32'd0);
   end

   // Expected {err, zero, result} for one operation.
   function automatic logic [33:0] ref_rsp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      logic [31:0] r;
      r = 32'd0;
      case (op)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: r = a + b;
         3'd6: r = a - b;
         3'd7: r = (a < b) ? 32'd1 : 32'd0;
         default: return {1'b1, 1'b1, 32'd0};
      endcase
      return {1'b0, (r == 32'd0), r};
   endfunction

   task automatic pulse_reset();
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      tie_pick = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 32'h11; req0_b = 32'h22; req0_op = 3'd2;
      req1_valid = 1'b1; req1_a = 32'h33; req1_b = 32'h44; req1_op = 3'd1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         checks++;
         if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++; $display("FAIL reset_ready cyc%0d: got %b%b want 00", i, req0_ready, req1_ready);
         end
         checks++;
         if (rsp_valid !== 1'b0) begin
            failures++; $display("FAIL reset_rsp_valid cyc%0d: got %b want 0", i, rsp_valid);
         end
         checks++;
         if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_control !== 3'd0) begin
            failures++; $display("FAIL reset_alu cyc%0d: got %h %h %h want 0 0 0", i, alu_a, alu_b, alu_control);
         end
      end
      @(negedge clk);
      reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      tie_pick = 1'b0;
   endtask

   task automatic test_single();
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd5; req0_op = 3'b110; rsp_ready = 1'b1; #1;
      checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         failures++; $display("FAIL single_grant: got %b%b want 10", req0_ready, req1_ready);
      end
      @(negedge clk); req0_valid = 1'b0; #1;
      checks++;
      if (rsp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
         failures++; $display("FAIL single_exec: rsp_valid=%b ready=%b%b want 0 00", rsp_valid, req0_ready, req1_ready);
      end
      checks++;
      if (alu_a !== 32'd7 || alu_b !== 32'd5 || alu_control !== 3'b110) begin
         failures++; $display("FAIL single_alu_drive: got %h %h %h want 7 5 6", alu_a, alu_b, alu_control);
      end
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd2 || rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin
         failures++; $display("FAIL single_rsp: got v=%b id=%b res=%h z=%b e=%b want 1 0 2 0 0",
                              rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err);
      end
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
         failures++; $display("FAIL single_after_hs: rsp_valid=%b want 0", rsp_valid);
      end
      tie_pick = 1'b1;
   endtask

   task automatic test_tie();
      int   gq[$];
      int   grants;
      int   rsps;
      logic exp_w;
      pulse_reset();
      grants = 0; rsps = 0; exp_w = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c == 0) begin
            req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_op = 3'b010;
            req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd9; req1_op = 3'b111;
            rsp_ready  = 1'b1;
         end
         #1;
         if (req0_ready || req1_ready) begin
            checks++;
            if ((req0_ready && req1_ready) || req1_ready !== exp_w) begin
               failures++; $display("FAIL tie_grant #%0d: got %b%b want id %b", grants, req0_ready, req1_ready, exp_w);
            end
            gq.push_back(c);
            exp_w = ~exp_w;
            grants++;
         end
         if (rsp_valid) begin
            checks++;
            if (rsps >= gq.size() || c != gq[rsps] + 2 || rsp_id !== rsps[0] ||
                rsp_result !== (rsps[0] ? 32'd1 : 32'd7) || rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin
               failures++; $display("FAIL tie_rsp #%0d cyc%0d: got id=%b res=%h z=%b e=%b want id=%0d res=%0d",
                                    rsps, c, rsp_id, rsp_result, rsp_zero, rsp_err, rsps % 2, (rsps % 2) ? 1 : 7);
            end
            rsps++;
         end
      end
      checks++;
      if (grants != 4 || rsps != 4) begin
         failures++; $display("FAIL tie_count: got grants=%0d rsps=%0d want 4 4", grants, rsps);
      end
      @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
      tie_pick = 1'b0;
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 32'h0000F0F0; req0_b = 32'h00000FF0; req0_op = 3'b000;
      req1_valid = 1'b1; req1_a = 32'h0000FF00; req1_b = 32'h000000F1; req1_op = 3'b001;
      rsp_ready = 1'b0; #1;
      checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         failures++; $display("FAIL bp_grant0: got %b%b want 10", req0_ready, req1_ready);
      end
      @(negedge clk);
      req0_a = 32'd10; req0_b = 32'd20; req0_op = 3'b010;  // requester 0 presents its next op
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'h000000F0 || rsp_zero !== 1'b0 ||
             rsp_err !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++; $display("FAIL bp_hold cyc%0d: got v=%b id=%b res=%h z=%b e=%b rdy=%b%b want 1 0 f0 0 0 00",
                                 i, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, req0_ready, req1_ready);
         end
      end
      @(negedge clk); rsp_ready = 1'b1; #1;
      checks++;
      if (rsp_valid !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
         failures++; $display("FAIL bp_handshake: got v=%b rdy=%b%b want 1 00", rsp_valid, req0_ready, req1_ready);
      end
      @(negedge clk); #1;
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
         failures++; $display("FAIL bp_next_grant: got %b%b want 01", req0_ready, req1_ready);
      end
      @(negedge clk); req1_valid = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'h0000FFF1 || rsp_err !== 1'b0) begin
         failures++; $display("FAIL bp_rsp1: got v=%b id=%b res=%h e=%b want 1 1 fff1 0", rsp_valid, rsp_id, rsp_result, rsp_err);
      end
      @(negedge clk); #1;
      checks++;
      if (req0_ready !== 1'b1) begin
         failures++; $display("FAIL bp_grant_again: got req0_ready=%b want 1", req0_ready);
      end
      @(negedge clk); req0_valid = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd30) begin
         failures++; $display("FAIL bp_rsp2: got v=%b id=%b res=%h want 1 0 1e", rsp_valid, rsp_id, rsp_result);
      end
      @(negedge clk);
      tie_pick = 1'b1;
   endtask

   task automatic test_illegal();
      logic        t_id  [3];
      logic [31:0] t_a   [3];
      logic [31:0] t_b   [3];
      logic [2:0]  t_op  [3];
      logic [33:0] t_exp [3];
      t_id[0] = 1'b1; t_a[0] = $urandom; t_b[0] = $urandom; t_op[0] = 3'b011; t_exp[0] = {1'b1, 1'b1, 32'd0};
      t_id[1] = 1'b0; t_a[1] = 32'd5;    t_b[1] = 32'd5;    t_op[1] = 3'b110; t_exp[1] = {1'b0, 1'b1, 32'd0};
      t_id[2] = 1'b0; t_a[2] = $urandom; t_b[2] = $urandom; t_op[2] = 3'b101; t_exp[2] = {1'b1, 1'b1, 32'd0};
      rsp_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         req0_valid = ~t_id[k]; req0_a = t_a[k]; req0_b = t_b[k]; req0_op = t_op[k];
         req1_valid =  t_id[k]; req1_a = t_a[k]; req1_b = t_b[k]; req1_op = t_op[k];
         #1;
         checks++;
         if (req1_ready !== t_id[k] || req0_ready !== ~t_id[k]) begin
            failures++; $display("FAIL illegal_grant #%0d: got %b%b want id %b", k, req0_ready, req1_ready, t_id[k]);
         end
         @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
         @(negedge clk); #1;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_id !== t_id[k] || {rsp_err, rsp_zero, rsp_result} !== t_exp[k]) begin
            failures++; $display("FAIL illegal_rsp #%0d op=%b: got v=%b id=%b e=%b z=%b res=%h want e=%b z=%b res=%h",
                                 k, t_op[k], rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_result,
                                 t_exp[k][33], t_exp[k][32], t_exp[k][31:0]);
         end
      end
      @(negedge clk);
      tie_pick = 1'b1;
   endtask

   task automatic test_reset_mid();
      rsp_ready = 1'b1;
      // Reset while the op sits in EXEC.
      @(negedge clk); req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 3'd2; req1_valid = 1'b0; #1;
      checks++;
      if (req0_ready !== 1'b1) begin
         failures++; $display("FAIL rmid_grant_a: got req0_ready=%b want 1", req0_ready);
      end
      @(negedge clk); req0_valid = 1'b0; reset = 1'b1;
      @(negedge clk); reset = 1'b0; #1;
      checks++;
      if (rsp_valid !== 1'b0 || alu_a !== 32'd0 || alu_b !== 32'd0 || alu_control !== 3'd0) begin
         failures++; $display("FAIL rmid_exec_clear: got v=%b alu=%h %h %h want 0 0 0 0", rsp_valid, alu_a, alu_b, alu_control);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         checks++;
         if (rsp_valid !== 1'b0) begin
            failures++; $display("FAIL rmid_exec_dropped cyc%0d: rsp_valid=%b want 0", i, rsp_valid);
         end
      end
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'd2;
      req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd2; req1_op = 3'd1;
      rsp_ready = 1'b0; #1;
      checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         failures++; $display("FAIL rmid_prio_after_exec: got %b%b want 10", req0_ready, req1_ready);
      end
      // Reset while the response is waiting in RESP.
      @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1) begin
         failures++; $display("FAIL rmid_resp_reached: rsp_valid=%b want 1", rsp_valid);
      end
      reset = 1'b1;
      @(negedge clk); reset = 1'b0; rsp_ready = 1'b1; #1;
      checks++;
      if (rsp_valid !== 1'b0 || alu_a !== 32'd0 || alu_control !== 3'd0) begin
         failures++; $display("FAIL rmid_resp_clear: got v=%b alu_a=%h ctl=%h want 0 0 0", rsp_valid, alu_a, alu_control);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         checks++;
         if (rsp_valid !== 1'b0) begin
            failures++; $display("FAIL rmid_resp_dropped cyc%0d: rsp_valid=%b want 0", i, rsp_valid);
         end
      end
      @(negedge clk); req0_valid = 1'b1; req1_valid = 1'b1; #1;
      checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         failures++; $display("FAIL rmid_prio_after_resp: got %b%b want 10", req0_ready, req1_ready);
      end
      @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tie_pick = 1'b1;
   endtask

   task automatic test_random();
      logic        pend [2];
      logic [31:0] pa   [2];
      logic [31:0] pb   [2];
      logic [2:0]  pop  [2];
      logic        outstanding;
      logic [33:0] exp_rsp;
      logic        exp_id;
      int          acc_cyc;
      logic        exp_any, exp_w, exp_rv;
      pulse_reset();
      outstanding = 1'b0; exp_rsp = '0; exp_id = 1'b0; acc_cyc = 0;
      for (int n = 0; n < 2; n++) begin
         pend[n] = 1'b0; pa[n] = '0; pb[n] = '0; pop[n] = '0;
      end
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         for (int n = 0; n < 2; n++) begin
            if (!pend[n] && ($urandom_range(0, 99) < 45)) begin
               pend[n] = 1'b1;
               pa[n]   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
               pb[n]   = ($urandom_range(0, 4) == 0) ? pa[n] : $urandom;
               pop[n]  = 3'($urandom_range(0, 7));
            end
         end
         req0_valid = pend[0]; req0_a = pa[0]; req0_b = pb[0]; req0_op = pop[0];
         req1_valid = pend[1]; req1_a = pa[1]; req1_b = pb[1]; req1_op = pop[1];
         rsp_ready  = ($urandom_range(0, 99) < 60);
         #1;
         exp_any = !outstanding && (pend[0] || pend[1]);
         exp_w   = (pend[0] && pend[1]) ? tie_pick : pend[1];
         exp_rv  = outstanding && (cyc >= acc_cyc + 2);
         checks++;
         if ((req0_ready && req1_ready) || ((req0_ready || req1_ready) !== exp_any)) begin
            failures++; $display("FAIL rnd_ready cyc%0d: got %b%b want any=%b", cyc, req0_ready, req1_ready, exp_any);
         end
         if (exp_any) begin
            checks++;
            if (req1_ready !== exp_w || req0_ready !== ~exp_w) begin
               failures++; $display("FAIL rnd_grant cyc%0d: got %b%b want id %b", cyc, req0_ready, req1_ready, exp_w);
            end
         end
         checks++;
         if (rsp_valid !== exp_rv) begin
            failures++; $display("FAIL rnd_rsp_valid cyc%0d: got %b want %b", cyc, rsp_valid, exp_rv);
         end
         if (exp_rv) begin
            checks++;
            if (rsp_id !== exp_id || {rsp_err, rsp_zero, rsp_result} !== exp_rsp) begin
               failures++; $display("FAIL rnd_rsp cyc%0d: got id=%b e=%b z=%b res=%h want id=%b e=%b z=%b res=%h",
                                    cyc, rsp_id, rsp_err, rsp_zero, rsp_result,
                                    exp_id, exp_rsp[33], exp_rsp[32], exp_rsp[31:0]);
            end
         end
         if (exp_any) begin
            outstanding = 1'b1;
            acc_cyc     = cyc;
            exp_id      = exp_w;
            exp_rsp     = ref_rsp(pa[exp_w], pb[exp_w], pop[exp_w]);
            tie_pick    = ~exp_w;
            pend[exp_w] = 1'b0;
         end else if (exp_rv && rsp_ready) begin
            outstanding = 1'b0;
         end
      end
      @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_backpressure();
      test_illegal();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
